// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider: RV32M divide op codes and FSM states.
package div_unit_pkg;

    // 2-bit divide op encoding driven by the decoder into EX.
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // Divider control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Signed variants treat operands as two's complement.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Remainder variants select the remainder instead of the quotient.
    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit_core.sv
// Unsigned restoring division datapath: one shift-subtract step per enabled cycle.
module div_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            fits;

    // Trial subtraction of the divisor from the remainder shifted by one dividend bit.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        fits    = (shifted >= {1'b0, dvs_q});
    end

    // Remainder/quotient shift pair: load fresh magnitudes, or advance one step.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], fits};
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/div_unit.sv
// RV32M iterative divider for EX: FSM, sign fix-up, special cases and pipeline stall.
import div_unit_pkg::*;

module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned     CNT_W   = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t       state_q;
    div_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;

    logic             signed_op;
    logic             div_zero;
    logic             overflow;
    logic             special;
    logic [XLEN-1:0]  dividend_mag;
    logic [XLEN-1:0]  divisor_mag;
    logic [XLEN-1:0]  special_res;

    logic             core_load;
    logic             core_step;
    logic [XLEN-1:0]  core_quo;
    logic [XLEN-1:0]  core_rem;

    logic             rem_sel_q;
    logic             quo_neg_q;
    logic             rem_neg_q;
    logic             fast_q;
    logic [XLEN-1:0]  fast_res_q;
    logic [XLEN-1:0]  result_q;
    logic [XLEN-1:0]  final_res;

    // Operand classification, magnitudes and the fast-path result.
    always_comb begin
        signed_op    = op_is_signed(op);
        div_zero     = (divisor == '0);
        overflow     = signed_op && (dividend == MIN_NEG) && (divisor == '1);
        special      = div_zero || overflow;
        dividend_mag = (signed_op && dividend[XLEN-1]) ? -dividend : dividend;
        divisor_mag  = (signed_op && divisor[XLEN-1])  ? -divisor  : divisor;
        if (div_zero) begin
            special_res = op_is_rem(op) ? dividend : '1;
        end else begin
            special_res = op_is_rem(op) ? '0 : MIN_NEG;
        end
    end

    div_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .step      (core_step),
        .dividend  (dividend_mag),
        .divisor   (divisor_mag),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, stall/done and datapath enables; reset forces everything quiet.
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        done      = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    stall     = 1'b1;
                    core_load = 1'b1;
                    state_d   = special ? DONE : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    core_step = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d   = IDLE;
            stall     = 1'b0;
            done      = 1'b0;
            core_load = 1'b0;
            core_step = 1'b0;
        end
    end

    // Iteration counter: loaded on a normal accept, counts down once per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (core_load && !special) begin
            cnt_q <= CNT_W'(XLEN);
        end else if (core_step) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end else if (state_q == CALC && flush) begin
            cnt_q <= '0;
        end
    end

    // Per-instruction context captured at accept: result selection, signs, fast path.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_sel_q  <= 1'b0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            fast_q     <= 1'b0;
            fast_res_q <= '0;
        end else if (core_load) begin
            rem_sel_q  <= op_is_rem(op);
            quo_neg_q  <= signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            rem_neg_q  <= signed_op && dividend[XLEN-1];
            fast_q     <= special;
            fast_res_q <= special_res;
        end
    end

    // Sign fix-up of the unsigned core result, or the captured special-case value.
    always_comb begin
        if (fast_q) begin
            final_res = fast_res_q;
        end else if (rem_sel_q) begin
            final_res = rem_neg_q ? -core_rem : core_rem;
        end else begin
            final_res = quo_neg_q ? -core_quo : core_quo;
        end
    end

    // Held result: refreshed on every completed operation, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else if (state_q == DONE) begin
            result_q <= final_res;
        end
    end

    // The core settles on the edge into DONE, so the DONE cycle shows the live value.
    always_comb begin
        result = (state_q == DONE && !rst) ? final_res : result_q;
    end

endmodule
